// File: rtl/oled_sdi_receiver.sv
// ---------------------------------------------------------------------------
// oled_sdi_receiver
// Receiving end of the 4-wire OLED serial link (nCS/DnC/SDIN/SCLK). Bytes are
// deserialised MSB-first on SCLK rising edges (detected in the HCLK domain).
// SetX (0x15), SetY (0x75) and SetPixel (0x5C) are decoded with their
// arguments. Each pair of pixel data bytes produces one 16-bit pixel write,
// addressed by an (x,y) pointer that walks the programmed window.
//
// Ports
//   HCLK, HRESETn        system clock, asynchronous active-low reset
//   nCS, DnC, SDIN, SCLK serial link inputs (sampled on HCLK rising edge)
//   pix_valid/x/y/colour one-cycle pixel write strobe and its data
//   cmd_valid/cmd_byte   one-cycle strobe for an unsupported command byte
//   frame_err            one-cycle strobe: nCS raised with a partial byte
//   data_err             one-cycle strobe: data byte received while Idle
//
// Configuration macro
//   OLED_RX_SYNC_EN      when defined, each link input passes through a
//                        2-flop synchroniser (all latencies grow by 2 HCLK)
// ---------------------------------------------------------------------------
module oled_sdi_receiver #(
    parameter int XW   = 7,
    parameter int YW   = 7,
    parameter int XMAX = 127,
    parameter int YMAX = 127
) (
    input  logic          HCLK,
    input  logic          HRESETn,
    input  logic          nCS,
    input  logic          DnC,
    input  logic          SDIN,
    input  logic          SCLK,
    output logic          pix_valid,
    output logic [XW-1:0] pix_x,
    output logic [YW-1:0] pix_y,
    output logic [15:0]   pix_colour,
    output logic          cmd_valid,
    output logic [7:0]    cmd_byte,
    output logic          frame_err,
    output logic          data_err
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_COLS  = 3'd1,
        ST_COLE  = 3'd2,
        ST_ROWS  = 3'd3,
        ST_ROWE  = 3'd4,
        ST_PIXHI = 3'd5,
        ST_PIXLO = 3'd6
    } state_t;

    localparam logic [XW-1:0] COL_E_RST = XW'(XMAX);
    localparam logic [YW-1:0] ROW_E_RST = YW'(YMAX);
    localparam logic [XW-1:0] X_ONE     = XW'(1);
    localparam logic [YW-1:0] Y_ONE     = YW'(1);

    logic ncs_s, dnc_s, sdin_s, sclk_s;

`ifdef OLED_RX_SYNC_EN
    logic [1:0] ncs_sync_r, dnc_sync_r, sdin_sync_r, sclk_sync_r;

    // Two-flop synchronisers; nCS resets to the deselected level.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            ncs_sync_r  <= 2'b11;
            dnc_sync_r  <= 2'b00;
            sdin_sync_r <= 2'b00;
            sclk_sync_r <= 2'b00;
        end else begin
            ncs_sync_r  <= {ncs_sync_r[0], nCS};
            dnc_sync_r  <= {dnc_sync_r[0], DnC};
            sdin_sync_r <= {sdin_sync_r[0], SDIN};
            sclk_sync_r <= {sclk_sync_r[0], SCLK};
        end
    end

    assign ncs_s  = ncs_sync_r[1];
    assign dnc_s  = dnc_sync_r[1];
    assign sdin_s = sdin_sync_r[1];
    assign sclk_s = sclk_sync_r[1];
`else
    assign ncs_s  = nCS;
    assign dnc_s  = DnC;
    assign sdin_s = SDIN;
    assign sclk_s = SCLK;
`endif

    logic          sclk_q_r;
    logic [6:0]    sr_r;      // only the 7 most recent bits are ever needed
    logic [2:0]    cnt_r;
    state_t        state_r, state_nx_s;
    logic [XW-1:0] col_s_r, col_e_r, x_r, col_s_nx_s, col_e_nx_s, x_nx_s;
    logic [YW-1:0] row_s_r, row_e_r, y_r, row_s_nx_s, row_e_nx_s, y_nx_s;
    logic [7:0]    hi_r, hi_nx_s;
    logic          rise_s, byte_done_s;
    logic [7:0]    byte_s;
    logic          pix_valid_nx_s, cmd_valid_nx_s, data_err_nx_s;
    logic [XW-1:0] pix_x_nx_s;
    logic [YW-1:0] pix_y_nx_s;
    logic [15:0]   pix_colour_nx_s;
    logic [7:0]    cmd_byte_nx_s;

    assign rise_s      = sclk_s & ~sclk_q_r & ~ncs_s;
    // cnt wraps 7->0 on the completing edge, so an nCS rise right after a
    // full byte sees cnt==0 and does not flag a framing error.
    assign byte_done_s = rise_s & (cnt_r == 3'd7);
    assign byte_s      = {sr_r, sdin_s};

    // SCLK edge detection, bit shifting and partial-byte framing check.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            sclk_q_r  <= 1'b0;
            sr_r      <= 7'd0;
            cnt_r     <= 3'd0;
            frame_err <= 1'b0;
        end else begin
            sclk_q_r  <= sclk_s;
            frame_err <= ncs_s & (cnt_r != 3'd0);
            if (rise_s) begin
                sr_r  <= byte_s[6:0];
                cnt_r <= cnt_r + 3'd1;
            end else if (ncs_s) begin
                cnt_r <= 3'd0;
            end
        end
    end

    // Byte decode: next state, window/pointer updates and strobe values.
    always_comb begin
        state_nx_s      = state_r;
        col_s_nx_s      = col_s_r;
        col_e_nx_s      = col_e_r;
        row_s_nx_s      = row_s_r;
        row_e_nx_s      = row_e_r;
        x_nx_s          = x_r;
        y_nx_s          = y_r;
        hi_nx_s         = hi_r;
        pix_valid_nx_s  = 1'b0;
        cmd_valid_nx_s  = 1'b0;
        data_err_nx_s   = 1'b0;
        pix_x_nx_s      = pix_x;
        pix_y_nx_s      = pix_y;
        pix_colour_nx_s = pix_colour;
        cmd_byte_nx_s   = cmd_byte;
        if (byte_done_s && !dnc_s) begin
            case (byte_s)
                8'h15: state_nx_s = ST_COLS;
                8'h75: state_nx_s = ST_ROWS;
                8'h5C: begin
                    x_nx_s     = col_s_r;
                    y_nx_s     = row_s_r;
                    state_nx_s = ST_PIXHI;
                end
                default: begin
                    cmd_valid_nx_s = 1'b1;
                    cmd_byte_nx_s  = byte_s;
                    state_nx_s     = ST_IDLE;
                end
            endcase
        end else if (byte_done_s) begin
            case (state_r)
                ST_IDLE: data_err_nx_s = 1'b1;
                ST_COLS: begin
                    col_s_nx_s = byte_s[XW-1:0];
                    state_nx_s = ST_COLE;
                end
                ST_COLE: begin
                    col_e_nx_s = (byte_s[XW-1:0] > col_s_r) ? byte_s[XW-1:0] : col_s_r;
                    state_nx_s = ST_IDLE;
                end
                ST_ROWS: begin
                    row_s_nx_s = byte_s[YW-1:0];
                    state_nx_s = ST_ROWE;
                end
                ST_ROWE: begin
                    row_e_nx_s = (byte_s[YW-1:0] > row_s_r) ? byte_s[YW-1:0] : row_s_r;
                    state_nx_s = ST_IDLE;
                end
                ST_PIXHI: begin
                    hi_nx_s    = byte_s;
                    state_nx_s = ST_PIXLO;
                end
                ST_PIXLO: begin
                    pix_valid_nx_s  = 1'b1;
                    pix_colour_nx_s = {hi_r, byte_s};
                    pix_x_nx_s      = x_r;
                    pix_y_nx_s      = y_r;
                    state_nx_s      = ST_PIXHI;
                    if (x_r == col_e_r) begin
                        x_nx_s = col_s_r;
                        if (y_r == row_e_r) begin
                            y_nx_s = row_s_r;
                        end else begin
                            y_nx_s = y_r + Y_ONE;
                        end
                    end else begin
                        x_nx_s = x_r + X_ONE;
                    end
                end
                default: state_nx_s = ST_IDLE;
            endcase
        end else begin
            state_nx_s = state_r;
        end
    end

    // State, window, pointer and registered output updates.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_r    <= ST_IDLE;
            col_s_r    <= '0;
            col_e_r    <= COL_E_RST;
            row_s_r    <= '0;
            row_e_r    <= ROW_E_RST;
            x_r        <= '0;
            y_r        <= '0;
            hi_r       <= 8'd0;
            pix_valid  <= 1'b0;
            pix_x      <= '0;
            pix_y      <= '0;
            pix_colour <= 16'd0;
            cmd_valid  <= 1'b0;
            cmd_byte   <= 8'd0;
            data_err   <= 1'b0;
        end else begin
            state_r    <= state_nx_s;
            col_s_r    <= col_s_nx_s;
            col_e_r    <= col_e_nx_s;
            row_s_r    <= row_s_nx_s;
            row_e_r    <= row_e_nx_s;
            x_r        <= x_nx_s;
            y_r        <= y_nx_s;
            hi_r       <= hi_nx_s;
            pix_valid  <= pix_valid_nx_s;
            pix_x      <= pix_x_nx_s;
            pix_y      <= pix_y_nx_s;
            pix_colour <= pix_colour_nx_s;
            cmd_valid  <= cmd_valid_nx_s;
            cmd_byte   <= cmd_byte_nx_s;
            data_err   <= data_err_nx_s;
        end
    end

endmodule

// File: tb/tb_oled_sdi_receiver.sv
// ---------------------------------------------------------------------------
// tb_oled_sdi_receiver
// Directed bench for oled_sdi_receiver: drives the serial link bit by bit,
// records every strobe seen on the outputs and compares the recorded events
// against hand-computed expectations in one task per scenario.
// ---------------------------------------------------------------------------
module tb_oled_sdi_receiver;

    logic        HCLK    = 1'b0;
    logic        HRESETn = 1'b1;
    logic        nCS     = 1'b1;
    logic        DnC     = 1'b0;
    logic        SDIN    = 1'b0;
    logic        SCLK    = 1'b0;
    logic        pix_valid;
    logic [6:0]  pix_x;
    logic [6:0]  pix_y;
    logic [15:0] pix_colour;
    logic        cmd_valid;
    logic [7:0]  cmd_byte;
    logic        frame_err;
    logic        data_err;

    oled_sdi_receiver dut (
        .HCLK       (HCLK),
        .HRESETn    (HRESETn),
        .nCS        (nCS),
        .DnC        (DnC),
        .SDIN       (SDIN),
        .SCLK       (SCLK),
        .pix_valid  (pix_valid),
        .pix_x      (pix_x),
        .pix_y      (pix_y),
        .pix_colour (pix_colour),
        .cmd_valid  (cmd_valid),
        .cmd_byte   (cmd_byte),
        .frame_err  (frame_err),
        .data_err   (data_err)
    );

    always #5 HCLK = ~HCLK;

    typedef struct packed {
        logic [6:0]  x;
        logic [6:0]  y;
        logic [15:0] c;
    } pix_t;

    int   n_checks = 0;
    int   n_fail   = 0;
    pix_t pix_q[$];
    int   cmd_cnt  = 0;
    int   ferr_cnt = 0;
    int   derr_cnt = 0;
    logic [7:0] last_cmd = 8'd0;

    // Event recorder: each strobe-high cycle is logged once (sampled mid-cycle).
    always @(negedge HCLK) begin
        if (HRESETn) begin
            if (pix_valid) pix_q.push_back({pix_x, pix_y, pix_colour});
            if (cmd_valid) begin
                cmd_cnt  = cmd_cnt + 1;
                last_cmd = cmd_byte;
            end
            if (frame_err) ferr_cnt = ferr_cnt + 1;
            if (data_err)  derr_cnt = derr_cnt + 1;
        end
    end

    task automatic clear_mon();
        @(posedge HCLK);
        pix_q.delete();
        cmd_cnt  = 0;
        ferr_cnt = 0;
        derr_cnt = 0;
    endtask

    task automatic send_bit(input logic b, input logic dc);
        @(negedge HCLK);
        SDIN = b;
        DnC  = dc;
        SCLK = 1'b0;
        @(negedge HCLK);
        SCLK = 1'b1;
        @(negedge HCLK);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic dc);
        nCS = 1'b0;
        for (int i = 7; i >= 0; i--) send_bit(b[i], dc);
    endtask

    task automatic idle(input int n);
        @(negedge HCLK);
        SCLK = 1'b0;
        repeat (n) @(negedge HCLK);
    endtask

    task automatic test_reset();
        #2 HRESETn = 1'b0;
        #1;
        n_checks++;
        if ({pix_valid, pix_x, pix_y, pix_colour, cmd_valid, cmd_byte, frame_err, data_err} !== 42'd0) begin
            $display("FAIL reset_outputs got %h expected 0",
                     {pix_valid, pix_x, pix_y, pix_colour, cmd_valid, cmd_byte, frame_err, data_err});
            n_fail++;
        end
        repeat (3) @(negedge HCLK);
        HRESETn = 1'b1;
        repeat (2) @(negedge HCLK);
    endtask

    task automatic test_window_and_frame();
        int k;
        logic [6:0] ex, ey;
        logic [7:0] b0, b1;
        clear_mon();
        send_byte(8'h15, 1'b0); send_byte(8'h10, 1'b1); send_byte(8'h17, 1'b1);
        send_byte(8'h75, 1'b0); send_byte(8'h20, 1'b1); send_byte(8'h2C, 1'b1);
        idle(8);
        n_checks++;
        if (pix_q.size() + cmd_cnt + ferr_cnt + derr_cnt != 0) begin
            $display("FAIL window_no_strobes got %0d strobes expected 0",
                     pix_q.size() + cmd_cnt + ferr_cnt + derr_cnt);
            n_fail++;
        end
        send_byte(8'h5C, 1'b0);
        for (int i = 0; i < 208; i++) send_byte(8'(i), 1'b1);
        idle(8);
        n_checks++;
        if (pix_q.size() != 104) begin
            $display("FAIL frame_pixel_count got %0d expected 104", pix_q.size());
            n_fail++;
        end
        for (k = 0; k < 104 && k < pix_q.size(); k++) begin
            ex = 7'(16 + (k % 8));
            ey = 7'(32 + (k / 8));
            b0 = 8'(2 * k);
            b1 = 8'(2 * k + 1);
            n_checks++;
            if (pix_q[k] !== {ex, ey, b0, b1}) begin
                $display("FAIL frame_pixel_%0d got (%0d,%0d,%h) expected (%0d,%0d,%h)",
                         k, pix_q[k].x, pix_q[k].y, pix_q[k].c, ex, ey, {b0, b1});
                n_fail++;
            end
        end
    endtask

    task automatic test_single_pixel_wrap();
        clear_mon();
        send_byte(8'h06, 1'b1); send_byte(8'h3C, 1'b1);
        idle(8);
        n_checks++;
        if (pix_q.size() != 1) begin
            $display("FAIL single_pixel_count got %0d expected 1", pix_q.size());
            n_fail++;
        end else begin
            n_checks++;
            if (pix_q[0] !== {7'd16, 7'd32, 16'h063C}) begin
                $display("FAIL single_pixel_wrap got (%0d,%0d,%h) expected (16,32,063c)",
                         pix_q[0].x, pix_q[0].y, pix_q[0].c);
                n_fail++;
            end
        end
    endtask

    task automatic test_cmd_abort();
        clear_mon();
        send_byte(8'h5C, 1'b0); send_byte(8'h11, 1'b1);
        send_byte(8'h5C, 1'b0); send_byte(8'h22, 1'b1); send_byte(8'h33, 1'b1);
        idle(8);
        n_checks++;
        if (pix_q.size() != 1 || pix_q[0] !== {7'd16, 7'd32, 16'h2233}) begin
            $display("FAIL cmd_abort got %0d pixels first=%h expected 1 pixel (16,32,2233)",
                     pix_q.size(), (pix_q.size() > 0) ? pix_q[0] : 30'd0);
            n_fail++;
        end
    endtask

    task automatic test_frame_err();
        clear_mon();
        idle(2);
        nCS = 1'b0;
        send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b0); send_bit(1'b1, 1'b0);
        idle(1);
        nCS = 1'b1;
        idle(8);
        n_checks++;
        if (ferr_cnt != 1) begin
            $display("FAIL frame_err_pulse got %0d cycles expected 1", ferr_cnt);
            n_fail++;
        end
        // 0x15 must decode cleanly after the dropped bits; col_e 4 clamps to 9.
        send_byte(8'h15, 1'b0); send_byte(8'h09, 1'b1); send_byte(8'h04, 1'b1);
        send_byte(8'h75, 1'b0); send_byte(8'h01, 1'b1); send_byte(8'h02, 1'b1);
        send_byte(8'h5C, 1'b0);
        send_byte(8'hC1, 1'b1); send_byte(8'hC2, 1'b1);
        send_byte(8'hC3, 1'b1); send_byte(8'hC4, 1'b1);
        idle(8);
        n_checks++;
        if (pix_q.size() != 2 || pix_q[0] !== {7'd9, 7'd1, 16'hC1C2} || pix_q[1] !== {7'd9, 7'd2, 16'hC3C4}) begin
            $display("FAIL post_frame_err_decode got %0d pixels expected (9,1,c1c2),(9,2,c3c4)", pix_q.size());
            n_fail++;
        end
        n_checks++;
        if (ferr_cnt != 1 || cmd_cnt != 0 || derr_cnt != 0) begin
            $display("FAIL post_frame_err_strobes got ferr=%0d cmd=%0d derr=%0d expected 1/0/0",
                     ferr_cnt, cmd_cnt, derr_cnt);
            n_fail++;
        end
    endtask

    task automatic test_unsupported_cmd();
        clear_mon();
        send_byte(8'hAF, 1'b0);
        idle(8);
        n_checks++;
        if (cmd_cnt != 1 || last_cmd !== 8'hAF) begin
            $display("FAIL cmd_valid got count=%0d byte=%h expected 1 af", cmd_cnt, last_cmd);
            n_fail++;
        end
        send_byte(8'h55, 1'b1);
        idle(8);
        n_checks++;
        if (derr_cnt != 1 || pix_q.size() != 0) begin
            $display("FAIL data_err_idle got derr=%0d pix=%0d expected 1 0", derr_cnt, pix_q.size());
            n_fail++;
        end
    endtask

    task automatic test_tiny_window_and_reset();
        clear_mon();
        send_byte(8'h15, 1'b0); send_byte(8'h05, 1'b1); send_byte(8'h05, 1'b1);
        send_byte(8'h75, 1'b0); send_byte(8'h07, 1'b1); send_byte(8'h07, 1'b1);
        send_byte(8'h5C, 1'b0);
        for (int i = 0; i < 6; i++) send_byte(8'hA1 + 8'(i), 1'b1);
        idle(8);
        n_checks++;
        if (pix_q.size() != 3) begin
            $display("FAIL tiny_window_count got %0d expected 3", pix_q.size());
            n_fail++;
        end
        for (int k = 0; k < 3 && k < pix_q.size(); k++) begin
            n_checks++;
            if (pix_q[k] !== {7'd5, 7'd7, 8'hA1 + 8'(2 * k), 8'hA2 + 8'(2 * k)}) begin
                $display("FAIL tiny_window_pixel_%0d got (%0d,%0d,%h) expected (5,7)",
                         k, pix_q[k].x, pix_q[k].y, pix_q[k].c);
                n_fail++;
            end
        end
        // Reset in the middle of a byte while pixel mode is active.
        nCS = 1'b0;
        for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b1);
        @(negedge HCLK);
        HRESETn = 1'b0;
        #1;
        n_checks++;
        if ({pix_valid, pix_x, pix_y, pix_colour, cmd_valid, cmd_byte, frame_err, data_err} !== 42'd0) begin
            $display("FAIL mid_byte_reset got %h expected 0",
                     {pix_valid, pix_x, pix_y, pix_colour, cmd_valid, cmd_byte, frame_err, data_err});
            n_fail++;
        end
        SCLK = 1'b0;
        repeat (3) @(negedge HCLK);
        HRESETn = 1'b1;
        clear_mon();
        send_byte(8'h5C, 1'b0); send_byte(8'h12, 1'b1); send_byte(8'h34, 1'b1);
        idle(8);
        n_checks++;
        if (pix_q.size() != 1 || pix_q[0] !== {7'd0, 7'd0, 16'h1234}) begin
            $display("FAIL post_reset_pixel got %0d pixels first=%h expected (0,0,1234)",
                     pix_q.size(), (pix_q.size() > 0) ? pix_q[0] : 30'd0);
            n_fail++;
        end
    endtask

    initial begin
        test_reset();
        test_window_and_frame();
        test_single_pixel_wrap();
        test_cmd_abort();
        test_frame_err();
        test_unsupported_cmd();
        test_tiny_window_and_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
